// File: rtl/mips_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : mips_trace_capture
// Purpose  : On-chip execution trace recorder for the single-cycle mips_cpu.
//            Stores {pc, instr, alu_result, reg_write, mem_write} records in a
//            DEPTH-entry buffer (circular or one-shot), detects program halt
//            (halt instruction or a stuck pc) and offers a 1-cycle readout.
// Revision : 1.0  initial release
// ============================================================================
module mips_trace_capture #(
    parameter int          DEPTH       = 16,
    parameter int          ADDR_W      = 4,
    parameter int          MODE        = 0,
    parameter logic [31:0] HALT_INSTR  = 32'h0000_000C,
    parameter int          HALT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              clear,
    input  logic              sample_valid,
    input  logic [31:0]       pc,
    input  logic [31:0]       instr,
    input  logic [31:0]       alu_result,
    input  logic              reg_write,
    input  logic              mem_write,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_idx,
    output logic [97:0]       rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              halted,
    output logic              capturing
);

    localparam int              c_REC_W     = 98;
    localparam int              c_STB_W     = $clog2(HALT_CYCLES + 1);
    localparam logic [ADDR_W:0] c_DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [c_STB_W-1:0] c_HC     = c_STB_W'(HALT_CYCLES);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_CAPTURE = 2'd1;
    localparam logic [1:0] c_DONE    = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W:0]    r_count;
    logic               r_overflow;
    logic               r_halted;
    logic               r_capturing;
    logic [c_STB_W-1:0] r_stable;
    logic [31:0]        r_last_pc;
    logic [c_REC_W-1:0] r_rd_data;
    logic               r_rd_valid;
    logic [c_REC_W-1:0] r_mem [DEPTH];

    logic               w_in_capture;
    logic               w_can_read;
    logic               w_full;
    logic               w_block;
    logic               w_take;
    logic               w_halt;
    logic [c_STB_W-1:0] w_stable_nxt;
    logic [ADDR_W-1:0]  w_oldest;
    logic [ADDR_W-1:0]  w_phys;
    logic               w_in_range;

    // Buffer bookkeeping shared by the FSM and the datapath. A one-shot buffer
    // that is full refuses further samples; a clear always wins over a sample.
    assign w_full       = (r_count == c_DEPTH_CNT);
    assign w_block      = (MODE == 1) && w_full;
    assign w_take       = w_in_capture && sample_valid && !clear && !w_block;
    assign w_stable_nxt = (r_stable != '0 && pc == r_last_pc)
                          ? ((r_stable == c_HC) ? r_stable : r_stable + c_STB_W'(1))
                          : c_STB_W'(1);
    assign w_halt       = w_take && ((instr == HALT_INSTR) || (w_stable_nxt >= c_HC));
    assign w_oldest     = w_full ? r_wr_ptr : '0;
    assign w_phys       = w_oldest + rd_idx;
    assign w_in_range   = ({1'b0, rd_idx} < r_count);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic: clear dominates, arm is only honoured in IDLE.
    always_comb begin
        w_next = r_state;
        if (clear) begin
            w_next = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:    if (arm) w_next = c_CAPTURE;
                c_CAPTURE: if (w_halt || w_block) w_next = c_DONE;
                c_DONE:    w_next = c_DONE;
                default:   w_next = c_IDLE;
            endcase
        end
    end

    // State-decoded qualifiers for capture and readout.
    always_comb begin
        w_in_capture = 1'b0;
        w_can_read   = 1'b0;
        case (r_state)
            c_CAPTURE: w_in_capture = 1'b1;
            c_IDLE,
            c_DONE:    w_can_read   = 1'b1;
            default:   w_can_read   = 1'b0;
        endcase
    end

    // Pointer, count, flag, halt-detector and readout registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_halted    <= 1'b0;
            r_capturing <= 1'b0;
            r_stable    <= '0;
            r_last_pc   <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_capturing <= (w_next == c_CAPTURE);
            if (clear) begin
                r_wr_ptr   <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
                r_halted   <= 1'b0;
                r_stable   <= '0;
            end else if (r_state == c_IDLE && arm) begin
                r_wr_ptr <= '0;
                r_count  <= '0;
                r_stable <= '0;
            end else if (w_take) begin
                r_wr_ptr  <= r_wr_ptr + ADDR_W'(1);
                r_stable  <= w_stable_nxt;
                r_last_pc <= pc;
                if (w_full) r_overflow <= 1'b1;
                else        r_count    <= r_count + (ADDR_W + 1)'(1);
                if (w_halt) r_halted   <= 1'b1;
            end

            if (rd_en && w_can_read) begin
                r_rd_valid <= 1'b1;
                r_rd_data  <= w_in_range ? r_mem[w_phys] : '0;
            end else begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    // Trace storage; contents deliberately survive reset for post-mortem reads.
    always_ff @(posedge clk) begin
        if (w_take) r_mem[r_wr_ptr] <= {pc, instr, alu_result, reg_write, mem_write};
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign halted    = r_halted;
    assign capturing = r_capturing;

endmodule
`default_nettype wire

// File: tb/tb_mips_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_trace_capture
// Purpose  : Directed self-checking bench. Three instances share stimulus:
//            DEPTH=4 circular, DEPTH=4 one-shot, and the default DEPTH=16.
// Revision : 1.0  initial release
// ============================================================================
module tb_mips_trace_capture;

    logic        clk = 1'b0;
    logic        reset, arm, clear, sample_valid, reg_write, mem_write, rd_en;
    logic [31:0] pc, instr, alu_result;
    logic [3:0]  rd_idx;

    logic [97:0] rd_data0, rd_data1, rd_data16;
    logic        rd_valid0, rd_valid1, rd_valid16;
    logic [2:0]  count0, count1;
    logic [4:0]  count16;
    logic        ovf0, ovf1, ovf16, halt0, halt1, halt16, cap0, cap1, cap16;

    int n_cmp = 0;
    int n_err = 0;
    logic [97:0] exp_rec [6];

    always #5 clk = ~clk;

    mips_trace_capture #(.DEPTH(4), .ADDR_W(2), .MODE(0)) u_dut0 (
        .clk(clk), .reset(reset), .arm(arm), .clear(clear), .sample_valid(sample_valid),
        .pc(pc), .instr(instr), .alu_result(alu_result), .reg_write(reg_write),
        .mem_write(mem_write), .rd_en(rd_en), .rd_idx(rd_idx[1:0]), .rd_data(rd_data0),
        .rd_valid(rd_valid0), .count(count0), .overflow(ovf0), .halted(halt0),
        .capturing(cap0));

    mips_trace_capture #(.DEPTH(4), .ADDR_W(2), .MODE(1)) u_dut1 (
        .clk(clk), .reset(reset), .arm(arm), .clear(clear), .sample_valid(sample_valid),
        .pc(pc), .instr(instr), .alu_result(alu_result), .reg_write(reg_write),
        .mem_write(mem_write), .rd_en(rd_en), .rd_idx(rd_idx[1:0]), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .count(count1), .overflow(ovf1), .halted(halt1),
        .capturing(cap1));

    mips_trace_capture u_dut16 (
        .clk(clk), .reset(reset), .arm(arm), .clear(clear), .sample_valid(sample_valid),
        .pc(pc), .instr(instr), .alu_result(alu_result), .reg_write(reg_write),
        .mem_write(mem_write), .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data16),
        .rd_valid(rd_valid16), .count(count16), .overflow(ovf16), .halted(halt16),
        .capturing(cap16));

    task automatic check_val(input string tag, input logic [97:0] obs, input logic [97:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [31:0] p, input logic [31:0] ins, input logic [31:0] alu,
                          input logic rw, input logic mw);
        sample_valid = 1'b1; pc = p; instr = ins; alu_result = alu;
        reg_write = rw; mem_write = mw;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic read(input logic [3:0] idx);
        rd_en = 1'b1; rd_idx = idx;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1; tick(); arm = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; arm = 1'b0; clear = 1'b0; sample_valid = 1'b0;
        pc = '0; instr = '0; alu_result = '0; reg_write = 1'b0; mem_write = 1'b0;
        rd_en = 1'b0; rd_idx = '0;
        for (int i = 0; i < 6; i++)
            exp_rec[i] = {32'(4 * i), (i == 5) ? 32'h0000_000C : (32'h2000_0000 | 32'(i)),
                          32'hA000_0000 + 32'(i), 1'(i), 1'(i >> 1)};
        repeat (2) tick();
        check_val("rst_count",    98'(count16),  98'd0);
        check_val("rst_halted",   98'(halt16),   98'd0);
        check_val("rst_capture",  98'(cap16),    98'd0);
        check_val("rst_rd_valid", 98'(rd_valid16), 98'd0);
        check_val("rst_rd_data",  rd_data16,     98'd0);
        reset = 1'b0;
        tick();

        // Wrap (circular) and stop (one-shot) with the same six samples
        pulse_arm();
        check_val("arm_capturing", 98'(cap0), 98'd1);
        for (int i = 0; i < 6; i++) begin
            if (i == 4) rd_en = 1'b1;
            sample(exp_rec[i][97:66], exp_rec[i][65:34], exp_rec[i][33:2],
                   exp_rec[i][1], exp_rec[i][0]);
            if (i == 4) begin
                rd_en = 1'b0;
                check_val("rd_in_capture0", 98'(rd_valid0), 98'd0);
                check_val("rd_in_capture1", 98'(rd_valid1), 98'd0);
            end
        end
        tick();
        check_val("wrap_count",    98'(count0), 98'd4);
        check_val("wrap_overflow", 98'(ovf0),   98'd1);
        check_val("wrap_halted",   98'(halt0),  98'd1);
        check_val("stop_count",    98'(count1), 98'd4);
        check_val("stop_overflow", 98'(ovf1),   98'd0);
        check_val("stop_halted",   98'(halt1),  98'd0);
        check_val("stop_capture",  98'(cap1),   98'd0);
        for (int k = 0; k < 4; k++) begin
            read(4'(k));
            check_val("wrap_rd_valid", 98'(rd_valid0), 98'd1);
            check_val("wrap_rd_data",  rd_data0, exp_rec[k + 2]);
            check_val("stop_rd_data",  rd_data1, exp_rec[k]);
        end

        // Halt instruction
        pulse_clear();
        check_val("clr_count",  98'(count16), 98'd0);
        check_val("clr_halted", 98'(halt16),  98'd0);
        pulse_arm();
        sample(32'd0,  32'h2000_0010, 32'd1, 1'b1, 1'b0);
        sample(32'd4,  32'h2000_0011, 32'd2, 1'b0, 1'b1);
        sample(32'd8,  32'h0000_000C, 32'd3, 1'b0, 1'b0);
        sample(32'd12, 32'h2000_0012, 32'd4, 1'b1, 1'b1);
        tick();
        check_val("hi_halted", 98'(halt16),  98'd1);
        check_val("hi_count",  98'(count16), 98'd3);
        read(4'd2);
        check_val("hi_rd_instr", 98'(rd_data16[65:34]), 98'h0000_000C);
        read(4'd5);
        check_val("oor_rd_valid", 98'(rd_valid16), 98'd1);
        check_val("oor_rd_data",  rd_data16, 98'd0);
        tick();
        check_val("no_rd_valid", 98'(rd_valid16), 98'd0);
        pulse_arm();
        tick();
        check_val("arm_in_done", 98'(cap16), 98'd0);

        // Stable-pc halt with an invalid cycle in the run
        pulse_clear();
        pulse_arm();
        sample(32'd0, 32'h1, 32'd0, 1'b0, 1'b0);
        sample(32'd4, 32'h2, 32'd0, 1'b0, 1'b0);
        sample(32'd8, 32'h3, 32'd0, 1'b0, 1'b0);
        sample(32'd8, 32'h3, 32'd0, 1'b0, 1'b0);
        tick();
        sample(32'd8, 32'h3, 32'd0, 1'b0, 1'b0);
        check_val("st_not_yet", 98'(halt16), 98'd0);
        sample(32'd8, 32'h3, 32'd0, 1'b0, 1'b0);
        check_val("st_halted", 98'(halt16), 98'd1);
        sample(32'd8, 32'h3, 32'd0, 1'b0, 1'b0);
        check_val("st_count", 98'(count16), 98'd6);

        // Clear and sample in the same cycle
        pulse_clear();
        pulse_arm();
        sample(32'd0, 32'h1, 32'd0, 1'b0, 1'b0);
        sample(32'd4, 32'h2, 32'd0, 1'b0, 1'b0);
        sample(32'd8, 32'h3, 32'd0, 1'b0, 1'b0);
        check_val("pre_clr_count", 98'(count16), 98'd3);
        clear = 1'b1;
        sample(32'd12, 32'h4, 32'd0, 1'b0, 1'b0);
        clear = 1'b0;
        tick();
        check_val("clrs_count",   98'(count16), 98'd0);
        check_val("clrs_capture", 98'(cap16),   98'd0);

        // Asynchronous reset mid-capture
        pulse_arm();
        sample(32'd0, 32'h1, 32'd0, 1'b0, 1'b0);
        sample(32'd4, 32'h2, 32'd0, 1'b0, 1'b0);
        sample(32'd8, 32'h3, 32'd0, 1'b0, 1'b0);
        #3 reset = 1'b1;
        #1;
        check_val("ar_count",    98'(count16), 98'd0);
        check_val("ar_halted",   98'(halt16),  98'd0);
        check_val("ar_overflow", 98'(ovf0),    98'd0);
        check_val("ar_capture",  98'(cap16),   98'd0);
        tick();
        reset = 1'b0;
        tick();
        pulse_arm();
        sample(32'd100, 32'h0000_000C, 32'h55, 1'b1, 1'b0);
        tick();
        check_val("ar_re_count", 98'(count16), 98'd1);
        read(4'd0);
        check_val("ar_re_rec", rd_data16, {32'd100, 32'h0000_000C, 32'h55, 1'b1, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
